// File: rtl/pipe_io_pkg.sv
// Shared definitions for the switch/key I/O path: widths, reset levels and
// the memory-mapped addresses the data-memory stage decodes.
package pipe_io_pkg;
    localparam int NUM_SW  = 10;
    localparam int NUM_KEY = 3;

    localparam logic [NUM_SW-1:0]  SW_RST  = '0;
    localparam logic [NUM_KEY-1:0] KEY_RST = 3'b111;

    localparam logic [31:0] IO_KEY_ADDR = 32'hffffff70;
    localparam logic [31:0] IO_SW_ADDR  = 32'hffffff80;
endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a counter that accepts a new
// level only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1     <= RST_VAL;
            r_s2     <= RST_VAL;
            r_stable <= RST_VAL;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            // Any agreement with the accepted level restarts the count, so a
            // glitch must persist for the full window before it is believed.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;
endmodule

// File: rtl/pipe_io_debounce.sv
// Conditions board switches and keys for the data-memory I/O read path:
// per-bit synchronize/debounce, key-press pulses and clearable sticky flags.
module pipe_io_debounce
    import pipe_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [NUM_KEY:1]   key_raw,
    input  logic [NUM_KEY:1]   event_clr,
    output logic [NUM_SW-1:0]  sw_out,
    output logic [NUM_KEY:1]   key_out,
    output logic [NUM_KEY:1]   key_press,
    output logic [NUM_KEY:1]   key_event
);
    logic [NUM_SW-1:0] w_sw_stable;
    logic [NUM_KEY:1]  w_key_stable;
    logic [NUM_KEY:1]  r_key_d;
    logic [NUM_KEY:1]  r_press;
    logic [NUM_KEY:1]  r_event;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RST_VAL         (SW_RST[i])
        ) u_bit (
            .clock    (clock),
            .reset    (reset),
            .i_raw    (sw_raw[i]),
            .o_stable (w_sw_stable[i])
        );
    end

    for (genvar i = 1; i <= NUM_KEY; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RST_VAL         (KEY_RST[i-1])
        ) u_bit (
            .clock    (clock),
            .reset    (reset),
            .i_raw    (key_raw[i]),
            .o_stable (w_key_stable[i])
        );
    end

    // Keys are active-low, so a press is a 1->0 edge of the debounced level;
    // a set in the same cycle as a clear wins so no press is ever dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_key_d <= KEY_RST;
            r_press <= '0;
            r_event <= '0;
        end else begin
            r_key_d <= w_key_stable;
            r_press <= r_key_d & ~w_key_stable;
            r_event <= r_press | (r_event & ~event_clr);
        end
    end

    assign sw_out    = w_sw_stable;
    assign key_out   = w_key_stable;
    assign key_press = r_press;
    assign key_event = r_event;
endmodule

// File: tb/tb_pipe_io_debounce.sv
// Directed scoreboard bench: each stimulus step queues the outputs expected
// after a given clock edge; a negedge monitor pops and compares them.
module tb_pipe_io_debounce;
    localparam int DC = 4;
    localparam int W  = 19;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] sw_raw = 10'h3ff;
    logic [3:1] key_raw = 3'b000;
    logic [3:1] event_clr = 3'b000;
    logic [9:0] sw_out;
    logic [3:1] key_out;
    logic [3:1] key_press;
    logic [3:1] key_event;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];
    int           cyc_q[$];
    string        name_q[$];

    pipe_io_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
        .clock     (clock),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .key_raw   (key_raw),
        .event_clr (event_clr),
        .sw_out    (sw_out),
        .key_out   (key_out),
        .key_press (key_press),
        .key_event (key_event)
    );

    // Clock and edge counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] v(input logic [9:0] s, input logic [2:0] k,
                                       input logic [2:0] p, input logic [2:0] e);
        return {s, k, p, e};
    endfunction

    // Driver helpers
    task automatic adv(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input string name, input int ahead, input logic [W-1:0] val);
        exp_q.push_back(val);
        cyc_q.push_back(cyc + ahead);
        name_q.push_back(name);
    endtask

    task automatic push_range(input string name, input int from, input int to,
                              input logic [W-1:0] val);
        for (int i = from; i <= to; i++) push(name, i, val);
    endtask

    // Monitor / scoreboard
    always @(negedge clock) begin
        logic [W-1:0] act;
        act = {sw_out, key_out, key_press, key_event};
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            logic [W-1:0] e;
            int           t;
            string        nm;
            e  = exp_q.pop_front();
            t  = cyc_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (t != cyc) begin
                n_fails++;
                $display("FAIL %s stale entry for cyc=%0d seen at cyc=%0d", nm, t, cyc);
            end else if (act !== e) begin
                n_fails++;
                $display("FAIL %s cyc=%0d actual sw=%h key=%b press=%b event=%b required sw=%h key=%b press=%b event=%b",
                         nm, cyc, act[18:9], act[8:6], act[5:3], act[2:0],
                         e[18:9], e[8:6], e[5:3], e[2:0]);
            end
        end
    end

    initial begin
        // Reset held for two edges with every raw pin opposite its reset level
        push_range("reset_hold", 1, 2, v(10'h000, 3'b111, 3'b000, 3'b000));
        adv(2);
        reset = 1'b0;
        push_range("reset_wait", 1, 5, v(10'h000, 3'b111, 3'b000, 3'b000));
        push("reset_accept", 6, v(10'h3ff, 3'b000, 3'b000, 3'b000));
        push("reset_press", 7, v(10'h3ff, 3'b000, 3'b111, 3'b000));
        push("reset_event", 8, v(10'h3ff, 3'b000, 3'b000, 3'b111));
        adv(8);

        // Return to idle levels; a release must not pulse
        key_raw = 3'b111;
        sw_raw  = 10'h000;
        push_range("idle_wait", 1, 5, v(10'h3ff, 3'b000, 3'b000, 3'b111));
        push_range("release_nopulse", 6, 7, v(10'h000, 3'b111, 3'b000, 3'b111));
        adv(7);
        event_clr = 3'b111;
        push("clear_all", 1, v(10'h000, 3'b111, 3'b000, 3'b000));
        adv(1);
        event_clr = 3'b000;
        push("clear_hold", 1, v(10'h000, 3'b111, 3'b000, 3'b000));
        adv(1);

        // Acceptance latency on sw[0]
        sw_raw = 10'h001;
        push_range("latency_wait", 1, 5, v(10'h000, 3'b111, 3'b000, 3'b000));
        push("latency_accept", 6, v(10'h001, 3'b111, 3'b000, 3'b000));
        adv(6);

        // Three-cycle glitch on key[2] is one short of the window
        key_raw = 3'b101;
        push_range("glitch", 1, 10, v(10'h001, 3'b111, 3'b000, 3'b000));
        adv(3);
        key_raw = 3'b111;
        adv(7);

        // Press and release key[1]
        key_raw = 3'b110;
        push_range("press_wait", 1, 5, v(10'h001, 3'b111, 3'b000, 3'b000));
        push("press_fall", 6, v(10'h001, 3'b110, 3'b000, 3'b000));
        push("press_pulse", 7, v(10'h001, 3'b110, 3'b001, 3'b000));
        push("press_event", 8, v(10'h001, 3'b110, 3'b000, 3'b001));
        adv(8);
        key_raw = 3'b111;
        push_range("press_held", 1, 5, v(10'h001, 3'b110, 3'b000, 3'b001));
        push_range("press_release", 6, 7, v(10'h001, 3'b111, 3'b000, 3'b001));
        adv(7);

        // Clear of key[3] coincides with its press pulse: set wins
        key_raw = 3'b011;
        push_range("setclr_wait", 1, 5, v(10'h001, 3'b111, 3'b000, 3'b001));
        push("setclr_fall", 6, v(10'h001, 3'b011, 3'b000, 3'b001));
        push("setclr_pulse", 7, v(10'h001, 3'b011, 3'b100, 3'b001));
        push("setclr_setwins", 8, v(10'h001, 3'b011, 3'b000, 3'b101));
        adv(7);
        event_clr = 3'b100;
        adv(1);
        event_clr = 3'b000;
        push_range("setclr_hold", 1, 2, v(10'h001, 3'b011, 3'b000, 3'b101));
        adv(2);
        event_clr = 3'b100;
        push("lone_clear", 1, v(10'h001, 3'b011, 3'b000, 3'b001));
        adv(1);
        event_clr = 3'b000;
        push("lone_clear_hold", 1, v(10'h001, 3'b011, 3'b000, 3'b001));
        adv(1);

        // Reset while sw[5] counter sits at 2
        sw_raw = 10'h021;
        push_range("midcnt_pre", 1, 4, v(10'h001, 3'b011, 3'b000, 3'b001));
        adv(4);
        reset = 1'b1;
        push_range("midcnt_reset", 1, 2, v(10'h000, 3'b111, 3'b000, 3'b000));
        adv(2);
        reset = 1'b0;
        push_range("midcnt_wait", 1, 5, v(10'h000, 3'b111, 3'b000, 3'b000));
        push("midcnt_accept", 6, v(10'h021, 3'b011, 3'b000, 3'b000));
        push("midcnt_pulse", 7, v(10'h021, 3'b011, 3'b100, 3'b000));
        push("midcnt_event", 8, v(10'h021, 3'b011, 3'b000, 3'b100));
        adv(8);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && cyc_q.size() > 0; i++) adv(1);
        if (cyc_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain actual=%0d pending required=0 pending", cyc_q.size());
        end
        adv(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/pipe_io_debounce.md
# pipe_io_debounce

Input conditioner for the board switches and push-keys that feed the I/O read path of the pipelined computer's data-memory stage. It synchronizes the raw `sw[9:0]` and `key[3:1]` pins into the CPU clock domain and debounces each bit with its own counter. It also produces one-cycle key-press pulses and software-clearable sticky press flags. Its stable outputs drive the data-memory stage's `sw`/`key` inputs, so CPU loads from the switch and key I/O addresses always see clean, glitch-free levels.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable clock cycles before a new level is accepted. This is 10 ms at 50 MHz. Legal range is ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of each debounce counter.

Ports:
- `clock`, in, 1: CPU clock. Single clock domain.
- `reset`, in, 1: reset. Synchronous, active-high.
- `sw_raw`, in, 10: asynchronous switch pins. 1 = switch up.
- `key_raw`, in, 3 (`[3:1]`): asynchronous key pins. Board polarity: 0 = pressed.
- `event_clr`, in, 3 (`[3:1]`): per-key clear of the sticky flags. Single-cycle strobe.
- `sw_out`, out, 10: debounced switch levels.
- `key_out`, out, 3 (`[3:1]`): debounced key levels, in board polarity (0 = pressed). This keeps existing software unchanged.
- `key_press`, out, 3 (`[3:1]`): one-cycle pulse on each debounced 1→0 transition of a key.
- `key_event`, out, 3 (`[3:1]`): sticky flag per key. Set by `key_press`, cleared by `event_clr`.

## Operation
- **Synchronizer:** each of the 13 raw bits passes through a 2-flop synchronizer (`s1` then `s2`). Reset values: key bits 1, switch bits 0.
- **Per-bit debounce:** each bit holds a `stable` register and a `cnt` register.
  - `s2 == stable`: `cnt <= 0`.
  - `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
- **Glitch rejection:** any return of `s2` to `stable` before acceptance zeroes `cnt`. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches the outputs.
- `sw_out` and `key_out` are the `stable` registers, with no further logic.
- `key_press[i]` is registered. It is 1 for exactly the cycle after the edge on which `stable[i]` goes 1→0. A 0→1 transition (release) produces no pulse.
- `key_event[i]` updates as follows:
  - if `key_press[i]` is asserted: set;
  - else if `event_clr[i]`: clear;
  - else: hold.
  - If set and clear coincide, set wins, so a press is never lost.
- Counter arithmetic is unsigned, `CNT_W` bits wide, and never wraps. The counter stops and resets at `DEBOUNCE_CYCLES-1`.
- **Reset (any cycle, including mid-count):**
  - `cnt` = 0 for every bit.
  - `stable`: keys 3'b111, switches 10'b0.
  - `key_press` = 0, `key_event` = 0.
  - A raw level that differs from the reset value after reset is re-debounced from zero.

## Timing
- Outputs are registered. No combinational path exists from any input to any output.
- **Acceptance latency:** a raw change is first captured into `s1` at clock edge E. `stable` and `sw_out`/`key_out` change on edge E + `DEBOUNCE_CYCLES` + 1. That is `DEBOUNCE_CYCLES` + 2 edges counting E as edge 1.
- `key_press` asserts on the edge after `key_out` falls and lasts one cycle.
- `key_event` rises on the same edge that `key_press` deasserts.
- `event_clr` takes effect on the next edge.
- All 13 bits are independent. Simultaneous changes on several bits are accepted on the same edge.

## Structure
- **Shared package `pipe_io_pkg`:**
  - `NUM_SW` = 10, `NUM_KEY` = 3.
  - Reset levels `SW_RST` = 10'b0 and `KEY_RST` = 3'b111.
  - The I/O addresses 32'hffffff70 (keys) and 32'hffffff80 (switches), so that the data-memory stage and this block share one definition.
- **One sub-module, `debounce_bit`:** contains the synchronizer, counter and `stable` register for one bit, with reset value and `DEBOUNCE_CYCLES` as parameters.
- **Top:** 13 instances of `debounce_bit`, plus the edge detector and the sticky-flag logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Reset:** assert `reset` for 2 cycles while `key_raw` = 3'b000 and `sw_raw` = 10'h3FF. Required: during reset `key_out` = 3'b111, `sw_out` = 0, `key_press` = 0 and `key_event` = 0. After release, `key_out` = 3'b000 and `sw_out` = 10'h3FF exactly 6 edges later.
- **Latency:** set `sw_raw[0]` 0→1 before edge 1 and hold it. Required: `sw_out[0]` = 0 through edge 5 and = 1 after edge 6.
- **Glitch rejection:** pulse `key_raw[2]` low for 3 cycles, then high. Required: `key_out[2]` stays 1, and `key_press` and `key_event` stay 0 throughout.
- **Press:** hold `key_raw[1]` low. Required: `key_out[1]` falls at edge 6, `key_press` = 3'b001 for exactly one cycle, then `key_event` = 3'b001 and it holds after the key is released.
- **Clear vs set:** pulse `event_clr[3]` in the same cycle that `key_press[3]` is asserted. Required: `key_event[3]` = 1. A later lone `event_clr[3]` gives `key_event[3]` = 0 on the next edge.
- **Reset mid-count:** assert `reset` at `cnt` = 2 while `sw_raw[5]` = 1. Required: `sw_out[5]` = 0 through reset, then rises 6 edges after reset deasserts, with no early acceptance from the stale count.
